// File: rtl/scan_link_receiver.sv
// scan_link_receiver: deserializes the scanner's bit-strobe/data link into
// frames, decodes commands, captures data bytes, drives readyForTransferOut.
//
// Ports:
//   clk, rst (async, active-low)
//   serClk, serData : strobe/data from the scanner (asynchronous)
//   hostReady       : downstream can take a data byte
//   readyForTransferOut, cmdValid, cmdCode, dataValid, dataByte,
//   startScanPulse, bufferFull, frameError : registered status/outputs
module scan_link_receiver #(
  parameter int FRAME_BITS  = 8,
  parameter int TIMEOUT     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serClk,
  input  logic                  serData,
  input  logic                  hostReady,
  output logic                  readyForTransferOut,
  output logic                  cmdValid,
  output logic [FRAME_BITS-1:0] cmdCode,
  output logic                  dataValid,
  output logic [FRAME_BITS-1:0] dataByte,
  output logic                  startScanPulse,
  output logic                  bufferFull,
  output logic                  frameError
);

  localparam int CW = $clog2(FRAME_BITS);
  localparam int TW = $clog2(TIMEOUT);
  localparam int FW = FRAME_BITS;

  localparam logic [FW-1:0] C_RDY   = FW'(2);
  localparam logic [FW-1:0] C_START = FW'(3);
  localparam logic [FW-1:0] C_FULL  = FW'(4);
  localparam logic [FW-1:0] C_DATA  = FW'(7);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_q, sclk_d;
  logic [SYNC_STAGES-1:0] sdat_q, sdat_d;
  logic                   sprev_q, sprev_d;

  logic [FW-2:0] sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic          rft_q, rft_d;
  logic          pend_q, pend_d;
  logic          cv_q, cv_d;
  logic [FW-1:0] code_q, code_d;
  logic          dv_q, dv_d;
  logic [FW-1:0] byte_q, byte_d;
  logic          ss_q, ss_d;
  logic          bf_q, bf_d;
  logic          fe_q, fe_d;

  logic          strobe;
  logic          bit_in;
  logic [FW-1:0] frame;
  logic          last;
  logic          tmo_hit;
  logic          cmd_done;
  logic          data_done;

  // Synchronizers and strobe edge detect
  always_comb begin
    sclk_d  = {sclk_q[SYNC_STAGES-2:0], serClk};
    sdat_d  = {sdat_q[SYNC_STAGES-2:0], serData};
    sprev_d = sclk_q[SYNC_STAGES-1];
  end

  assign strobe = sclk_q[SYNC_STAGES-1] & ~sprev_q;
  assign bit_in = sdat_q[SYNC_STAGES-1];

  // Complete frame as it would look after shifting in the current bit
  assign frame = {bit_in, sh_q};

  assign last = strobe && (state_q != HUNT)
             && (cnt_q == CW'(FRAME_BITS - 1));

  // Timeout fires on the TIMEOUT-th idle cycle after the last bit
  assign tmo_hit = !strobe && (state_q != HUNT)
                && (tmo_q == TW'(TIMEOUT - 1));

  assign cmd_done  = last && (state_q == CMD);
  assign data_done = last && (state_q == DATA);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and frame datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    sh_d    = sh_q;
    if (strobe) begin
      sh_d  = frame[FW-1:1];
      tmo_d = '0;
    end else if (state_q != HUNT) begin
      tmo_d = tmo_q + TW'(1);
    end
    unique case (state_q)
      HUNT: begin
        if (strobe) begin
          state_d = CMD;
          cnt_d   = CW'(1);
        end
      end
      CMD, DATA: begin
        if (last) begin
          cnt_d   = '0;
          state_d = (state_q == CMD && frame == C_DATA)
                  ? DATA : HUNT;
        end else if (strobe) begin
          cnt_d = cnt_q + CW'(1);
        end else if (tmo_hit) begin
          state_d = HUNT;
          cnt_d   = '0;
          tmo_d   = '0;
          sh_d    = '0;
        end
      end
      default: begin
        state_d = HUNT;
        cnt_d   = '0;
        tmo_d   = '0;
      end
    endcase
  end

  // Output next values
  always_comb begin
    rft_d  = rft_q;
    pend_d = pend_q;
    cv_d   = 1'b0;
    code_d = code_q;
    dv_d   = 1'b0;
    byte_d = byte_q;
    ss_d   = 1'b0;
    bf_d   = bf_q;
    fe_d   = fe_q;
    // A deferred READY_TO_TRANSFER waits for hostReady
    if (pend_q && hostReady) begin
      rft_d  = 1'b1;
      pend_d = 1'b0;
    end
    if (tmo_hit) begin
      fe_d = 1'b1;
    end
    if (cmd_done) begin
      case (frame)
        C_RDY: begin
          cv_d   = 1'b1;
          code_d = frame;
          if (hostReady) begin
            rft_d = 1'b1;
          end else if (!rft_q) begin
            pend_d = 1'b1;
          end
        end
        C_START: begin
          cv_d   = 1'b1;
          code_d = frame;
          ss_d   = 1'b1;
          fe_d   = 1'b0;
          rft_d  = 1'b0;
          pend_d = 1'b0;
        end
        C_FULL: begin
          cv_d   = 1'b1;
          code_d = frame;
          bf_d   = 1'b1;
        end
        C_DATA: begin
          cv_d   = 1'b1;
          code_d = frame;
        end
        default: begin
          fe_d = 1'b1;
        end
      endcase
    end
    if (data_done) begin
      dv_d   = 1'b1;
      byte_d = frame;
      bf_d   = 1'b0;
      rft_d  = 1'b0;
      pend_d = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q  <= '0;
      sdat_q  <= '0;
      sprev_q <= 1'b0;
      sh_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      rft_q   <= 1'b0;
      pend_q  <= 1'b0;
      cv_q    <= 1'b0;
      code_q  <= '0;
      dv_q    <= 1'b0;
      byte_q  <= '0;
      ss_q    <= 1'b0;
      bf_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      sclk_q  <= sclk_d;
      sdat_q  <= sdat_d;
      sprev_q <= sprev_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      rft_q   <= rft_d;
      pend_q  <= pend_d;
      cv_q    <= cv_d;
      code_q  <= code_d;
      dv_q    <= dv_d;
      byte_q  <= byte_d;
      ss_q    <= ss_d;
      bf_q    <= bf_d;
      fe_q    <= fe_d;
    end
  end

  assign readyForTransferOut = rft_q;
  assign cmdValid            = cv_q;
  assign cmdCode             = code_q;
  assign dataValid           = dv_q;
  assign dataByte            = byte_q;
  assign startScanPulse      = ss_q;
  assign bufferFull          = bf_q;
  assign frameError          = fe_q;

endmodule
